cam_param_writer: RTL and testbench

- Downstream consumer of the debounced push-button value stage (11-bit value, 80..170, step 2).
- Turns each settled value change into one 8-bit OV5640 register write request to the existing SCCB master over a req/ack/done handshake.
- Handles settle, rate limiting, coalescing of changes made while busy, retry and timeout.
- Sits between the key stage and the SCCB master, after the power-up camera configuration sequence.

---
 rtl/cam_cfg_pkg.sv | 18 +
 rtl/param_clamp.sv | 66 ++++++
 rtl/cam_param_writer.sv | 139 +++++++++++++
 tb/tb_cam_param_writer.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cam_cfg_pkg.sv
// Shared constants for the camera parameter writer:
// FSM encoding, OV5640 register map and SCCB handshake widths.
package cam_cfg_pkg;

   localparam int ADDR_W = 16;
   localparam int DATA_W = 8;
   localparam int VAL_W  = 11;
   localparam int TMR_W  = 24;

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_SETTLE = 2'd1;
   localparam logic [1:0] ST_REQ    = 2'd2;
   localparam logic [1:0] ST_WAIT   = 2'd3;

   localparam logic [ADDR_W-1:0] OV5640_SDE_CTRL0 = 16'h5580;
   localparam logic [ADDR_W-1:0] OV5640_SDE_CTRL7 = 16'h5587;

endpackage

// File: rtl/param_clamp.sv
// Clamps the key value into range and tracks how long the
// clamped value has stayed unchanged.
module param_clamp
   import cam_cfg_pkg::*;
#(
   parameter logic [VAL_W-1:0] VAL_MIN    = 11'd80,
   parameter logic [VAL_W-1:0] VAL_MAX    = 11'd170,
   parameter logic [TMR_W-1:0] SETTLE_CYC = 24'd200_000
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [VAL_W-1:0] key_value_i,
   input  logic             arm_i,
   input  logic             track_i,
   output logic [VAL_W-1:0] cval_o,
   output logic [VAL_W-1:0] sample_o,
   output logic             stable_o
);

   // Loaded one short so the write fires SETTLE_CYC cycles after the change.
   localparam logic [TMR_W-1:0] LOAD =
      (SETTLE_CYC == '0) ? '0 : SETTLE_CYC - TMR_W'(1);

   logic [VAL_W-1:0] sample_q, sample_d;
   logic [TMR_W-1:0] tmr_q, tmr_d;

   always_comb begin
      if (key_value_i < VAL_MIN)
         cval_o = VAL_MIN;
      else if (key_value_i > VAL_MAX)
         cval_o = VAL_MAX;
      else
         cval_o = key_value_i;
   end

   always_comb begin
      sample_d = sample_q;
      tmr_d    = tmr_q;
      if (arm_i) begin
         sample_d = cval_o;
         tmr_d    = LOAD;
      end else if (track_i) begin
         if (cval_o != sample_q) begin
            sample_d = cval_o;
            tmr_d    = LOAD;
         end else if (tmr_q != '0) begin
            tmr_d = tmr_q - TMR_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sample_q <= '0;
         tmr_q    <= '0;
      end else begin
         sample_q <= sample_d;
         tmr_q    <= tmr_d;
      end
   end

   assign sample_o = sample_q;
   assign stable_o = track_i && (cval_o == sample_q)
                     && (tmr_q <= TMR_W'(1));

endmodule

// File: rtl/cam_param_writer.sv
// Turns settled key value changes into single OV5640 register
// writes via the SCCB master, with retry and timeout handling.
module cam_param_writer
   import cam_cfg_pkg::*;
#(
   parameter logic [ADDR_W-1:0] REG_ADDR    = OV5640_SDE_CTRL7,
   parameter logic [VAL_W-1:0]  VAL_MIN     = 11'd80,
   parameter logic [VAL_W-1:0]  VAL_MAX     = 11'd170,
   parameter logic [TMR_W-1:0]  SETTLE_CYC  = 24'd200_000,
   parameter logic [TMR_W-1:0]  TIMEOUT_CYC = 24'd1_000_000,
   parameter logic [1:0]        MAX_RETRY   = 2'd2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [VAL_W-1:0]  key_value,
   input  logic              cfg_done,
   output logic              wr_req,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [DATA_W-1:0] wr_data,
   input  logic              wr_ack,
   input  logic              wr_done,
   input  logic              wr_err,
   output logic              busy,
   output logic              err_flag
);

   logic [1:0]       state_q, state_d;
   logic [VAL_W-1:0] last_q, last_d;
   logic             pend_q, pend_d;
   logic [1:0]       retry_q, retry_d;
   logic [TMR_W-1:0] tmo_q, tmo_d;
   logic             err_q, err_d;

   logic             arm;
   logic             track;
   logic             stable;
   logic [VAL_W-1:0] cval;
   logic [VAL_W-1:0] sample_val;

   assign track = (state_q == ST_SETTLE);

   param_clamp #(
      .VAL_MIN    (VAL_MIN),
      .VAL_MAX    (VAL_MAX),
      .SETTLE_CYC (SETTLE_CYC)
   ) u_clamp (
      .clk         (clk),
      .rst_n       (rst_n),
      .key_value_i (key_value),
      .arm_i       (arm),
      .track_i     (track),
      .cval_o      (cval),
      .sample_o    (sample_val),
      .stable_o    (stable)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         last_q  <= '0;
         pend_q  <= 1'b1;
         retry_q <= '0;
         tmo_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
         pend_q  <= pend_d;
         retry_q <= retry_d;
         tmo_q   <= tmo_d;
         err_q   <= err_d;
      end
   end

   always_comb begin
      state_d = state_q;
      last_d  = last_q;
      pend_d  = pend_q;
      retry_d = retry_q;
      tmo_d   = tmo_q;
      err_d   = err_q;
      arm     = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (cfg_done && (pend_q || cval != last_q)) begin
               state_d = ST_SETTLE;
               arm     = 1'b1;
            end
         end
         ST_SETTLE: begin
            if (!cfg_done)
               state_d = ST_IDLE;
            else if (stable)
               state_d = ST_REQ;
         end
         ST_REQ: begin
            if (wr_ack) begin
               state_d = ST_WAIT;
               tmo_d   = TIMEOUT_CYC;
            end
         end
         ST_WAIT: begin
            if (tmo_q != '0)
               tmo_d = tmo_q - TMR_W'(1);
            // A completion in the expiry cycle takes priority.
            if (wr_done && !wr_err) begin
               state_d = ST_IDLE;
               last_d  = sample_val;
               pend_d  = 1'b0;
               err_d   = 1'b0;
               retry_d = '0;
               tmo_d   = '0;
            end else if (wr_done || tmo_q <= TMR_W'(1)) begin
               tmo_d = '0;
               if (retry_q < MAX_RETRY) begin
                  retry_d = retry_q + 2'd1;
                  state_d = ST_REQ;
               end else begin
                  state_d = ST_IDLE;
                  err_d   = 1'b1;
                  last_d  = sample_val;
                  pend_d  = 1'b0;
                  retry_d = '0;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      wr_req   = (state_q == ST_REQ);
      busy     = (state_q != ST_IDLE);
      wr_addr  = REG_ADDR;
      wr_data  = sample_val[DATA_W-1:0];
      err_flag = err_q;
   end

endmodule

// File: tb/tb_cam_param_writer.sv
// Directed plus randomized bench for cam_param_writer with a
// transaction-level model of which values get written.
module tb_cam_param_writer;

   localparam int S = 16;
   localparam int T = 64;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [10:0] key_value;
   logic        cfg_done;
   logic        wr_req;
   logic [15:0] wr_addr;
   logic [7:0]  wr_data;
   logic        wr_ack;
   logic        wr_done;
   logic        wr_err;
   logic        busy;
   logic        err_flag;

   int errs   = 0;
   int checks = 0;
   int rises  = 0;
   logic req_prev = 1'b0;

   always #5 clk = ~clk;

   cam_param_writer #(
      .SETTLE_CYC  (24'(S)),
      .TIMEOUT_CYC (24'(T)),
      .MAX_RETRY   (2'd2)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .key_value (key_value),
      .cfg_done  (cfg_done),
      .wr_req    (wr_req),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .wr_ack    (wr_ack),
      .wr_done   (wr_done),
      .wr_err    (wr_err),
      .busy      (busy),
      .err_flag  (err_flag)
   );

   always @(posedge clk) begin
      if (wr_req && !req_prev)
         rises <= rises + 1;
      req_prev <= wr_req;
   end

   function automatic int clampv(int k);
      if (k < 80) return 80;
      if (k > 170) return 170;
      return k;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wait_req(input string tag, output int lat);
      lat = 0;
      while (wr_req !== 1'b1 && lat < 400) begin
         @(negedge clk);
         lat++;
      end
      chk({tag, "_req"}, 32'(wr_req), 32'd1);
   endtask

   task automatic do_ack();
      wr_ack = 1'b1;
      @(negedge clk);
      wr_ack = 1'b0;
   endtask

   task automatic do_done(input logic e, input int dly);
      step(dly);
      wr_done = 1'b1;
      wr_err  = e;
      @(negedge clk);
      wr_done = 1'b0;
      wr_err  = 1'b0;
   endtask

   initial begin
      int lat;
      int r0;
      int last;
      int k;
      int kv;

      rst_n     = 1'b0;
      cfg_done  = 1'b0;
      key_value = 11'd80;
      wr_ack    = 1'b0;
      wr_done   = 1'b0;
      wr_err    = 1'b0;
      last      = -1;
      step(3);
      chk("rst_req", 32'(wr_req), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_err", 32'(err_flag), 32'd0);
      chk("rst_addr", 32'(wr_addr), 32'h5587);
      chk("rst_data", 32'(wr_data), 32'd0);
      rst_n = 1'b1;
      step(5);
      chk("nocfg_busy", 32'(busy), 32'd0);

      // initial write once the camera is configured
      cfg_done = 1'b1;
      wait_req("init", lat);
      chk("init_lat", lat, S);
      chk("init_addr", 32'(wr_addr), 32'h5587);
      chk("init_data", 32'(wr_data), 32'(clampv(80)));
      do_ack();
      do_done(1'b0, 3);
      last = clampv(80);
      chk("init_busy", 32'(busy), 32'd0);
      chk("init_err", 32'(err_flag), 32'd0);
      r0 = rises;
      step(40);
      chk("hold_norq", rises, r0);

      // rapid changes coalesce into one write
      r0 = rises;
      key_value = 11'd82;
      step(5);
      key_value = 11'd84;
      wait_req("coal", lat);
      chk("coal_lat", lat, S);
      chk("coal_data", 32'(wr_data), 32'd84);
      do_ack();
      do_done(1'b0, 2);
      last = 84;
      step(30);
      chk("coal_cnt", rises, r0 + 1);

      // clamp at both ends
      key_value = 11'd200;
      wait_req("hi", lat);
      chk("hi_data", 32'(wr_data), 32'(clampv(200)));
      do_ack();
      do_done(1'b0, 2);
      key_value = 11'd10;
      wait_req("lo", lat);
      chk("lo_data", 32'(wr_data), 32'(clampv(10)));
      do_ack();
      do_done(1'b0, 2);
      last = clampv(10);

      // three failing attempts end in the sticky error
      r0 = rises;
      key_value = 11'd120;
      for (int i = 0; i < 3; i++) begin
         wait_req("nack", lat);
         chk("nack_data", 32'(wr_data), 32'd120);
         do_ack();
         do_done(1'b1, 2);
      end
      step(3);
      chk("nack_busy", 32'(busy), 32'd0);
      chk("nack_err", 32'(err_flag), 32'd1);
      step(40);
      chk("nack_cnt", rises, r0 + 3);
      last = 120;

      key_value = 11'd90;
      wait_req("recov", lat);
      chk("recov_data", 32'(wr_data), 32'd90);
      do_ack();
      do_done(1'b0, 2);
      chk("recov_err", 32'(err_flag), 32'd0);
      last = 90;

      // timeout retry, then a change made during WAIT
      key_value = 11'd96;
      wait_req("tmo", lat);
      do_ack();
      wait_req("tmo_retry", lat);
      chk("tmo_lat", lat, T);
      chk("tmo_data", 32'(wr_data), 32'd96);
      do_ack();
      step(4);
      key_value = 11'd100;
      do_done(1'b0, 4);
      wait_req("late", lat);
      chk("late_data", 32'(wr_data), 32'd100);
      do_ack();
      do_done(1'b0, 2);
      chk("late_err", 32'(err_flag), 32'd0);
      last = 100;

      // random values against the model
      for (int i = 0; i < 10; i++) begin
         k = int'($urandom_range(0, 300));
         if ((i % 3) == 2) k = last;
         key_value = 11'(k);
         if (clampv(k) == last) begin
            r0 = rises;
            step(S + 10);
            chk("rnd_norq", rises, r0);
         end else begin
            wait_req("rnd", lat);
            chk("rnd_lat", lat, S);
            chk("rnd_data", 32'(wr_data), 32'(clampv(k)));
            do_ack();
            do_done(1'b0, int'($urandom_range(0, 6)));
            chk("rnd_busy", 32'(busy), 32'd0);
            last = clampv(k);
         end
      end

      // reset in the middle of a transaction
      kv = (last == 130) ? 132 : 130;
      key_value = 11'(kv);
      wait_req("mid", lat);
      do_ack();
      step(3);
      rst_n    = 1'b0;
      cfg_done = 1'b0;
      @(negedge clk);
      chk("mid_req", 32'(wr_req), 32'd0);
      chk("mid_busy", 32'(busy), 32'd0);
      rst_n = 1'b1;
      last  = -1;
      r0    = rises;
      do_done(1'b0, 1);
      step(5);
      chk("stray_busy", 32'(busy), 32'd0);
      chk("stray_cnt", rises, r0);
      cfg_done = 1'b1;
      wait_req("reinit", lat);
      chk("reinit_lat", lat, S);
      chk("reinit_data", 32'(wr_data), 32'(clampv(kv)));
      do_ack();
      do_done(1'b0, 2);
      chk("reinit_busy", 32'(busy), 32'd0);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
